store_coalesce_buffer: RTL and testbench

STORE_COALESCE_BUFFER -- requirements
Module: store_coalesce_buffer

---
 rtl/store_coalesce_buffer_pkg.sv | 10 +
 rtl/store_coalesce_buffer_sb_ring.sv | 61 ++++++
 rtl/store_coalesce_buffer.sv | 163 ++++++++++++++++
 tb/tb_store_coalesce_buffer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_coalesce_buffer_pkg.sv
// Shared constants and helpers for the store coalescing buffer and its ring queues.
package store_coalesce_buffer_pkg;

  localparam int unsigned SB_PAGE_OFF_W = 12;

  function automatic int unsigned sb_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/store_coalesce_buffer_sb_ring.sv
// Circular buffer with head/tail/count, full entry visibility and a write port into the youngest entry.
module sb_ring
  import store_coalesce_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = sb_cnt_w(DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  input  logic                      push_i,
  input  logic [W-1:0]              push_data_i,
  input  logic                      pop_i,
  input  logic                      tail_wr_i,
  input  logic [W-1:0]              tail_wr_data_i,
  output logic [DEPTH-1:0][W-1:0]   entries_o,
  output logic [DEPTH-1:0]          valid_o,
  output logic [PTR_W-1:0]          head_o,
  output logic [CNT_W-1:0]          count_o
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_youngest;

  assign w_youngest = r_tail - PTR_W'(1);
  assign head_o     = r_head;
  assign count_o    = r_count;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push_i) r_tail <= r_tail + PTR_W'(1);
      if (pop_i)  r_head <= r_head + PTR_W'(1);
      r_count <= r_count + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Payload storage is never reset; validity comes from the head/count window.
  always_ff @(posedge clk_i) begin
    if (push_i)         r_mem[r_tail]     <= push_data_i;
    else if (tail_wr_i) r_mem[w_youngest] <= tail_wr_data_i;
  end

  always_comb begin
    valid_o   = '0;
    entries_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries_o[i] = r_mem[i];
      valid_o[i]   = CNT_W'(PTR_W'(PTR_W'(i) - r_head)) < r_count;
    end
  end

endmodule

// File: rtl/store_coalesce_buffer.sv
// Store buffer: speculative queue feeding a write-combining commit queue that issues to memory.
module store_coalesce_buffer
  import store_coalesce_buffer_pkg::*;
#(
  parameter int unsigned SPEC_DEPTH   = 4,
  parameter int unsigned COMMIT_DEPTH = 8,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned PLEN         = 56,
  parameter int unsigned MAX_OUTST    = 2,
  parameter bit          COALESCE     = 1'b1,
  localparam int unsigned BE_W        = DATA_W / 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [PLEN-1:0]          paddr_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic [BE_W-1:0]          be_i,
  input  logic                     commit_i,
  output logic                     commit_ready_o,
  input  logic [SB_PAGE_OFF_W-1:0] page_offset_i,
  output logic                     page_offset_matches_o,
  output logic                     mem_req_o,
  input  logic                     mem_gnt_i,
  output logic [PLEN-1:0]          mem_addr_o,
  output logic [DATA_W-1:0]        mem_data_o,
  output logic [BE_W-1:0]          mem_be_o,
  input  logic                     mem_ack_i,
  output logic                     no_st_pending_o,
  output logic                     empty_o
);

  localparam int unsigned OFF_W      = $clog2(BE_W);
  localparam int unsigned SPEC_PTR_W = $clog2(SPEC_DEPTH);
  localparam int unsigned COM_PTR_W  = $clog2(COMMIT_DEPTH);
  localparam int unsigned SPEC_CNT_W = sb_cnt_w(SPEC_DEPTH);
  localparam int unsigned COM_CNT_W  = sb_cnt_w(COMMIT_DEPTH);
  localparam int unsigned OUT_W      = $clog2(MAX_OUTST + 1);
  localparam logic [PLEN-1:0]          WORD_MASK = {PLEN{1'b1}} << OFF_W;
  localparam logic [SB_PAGE_OFF_W-1:0] PAGE_MASK = {SB_PAGE_OFF_W{1'b1}} << OFF_W;

  typedef struct packed {
    logic [PLEN-1:0]   paddr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
    logic              valid;
  } sb_entry_t;

  localparam int unsigned ENTRY_W = $bits(sb_entry_t);

  sb_entry_t [SPEC_DEPTH-1:0]   w_spec_entries;
  sb_entry_t [COMMIT_DEPTH-1:0] w_com_entries;
  logic [SPEC_DEPTH-1:0]        w_spec_valid;
  logic [COMMIT_DEPTH-1:0]      w_com_valid;
  logic [SPEC_PTR_W-1:0]        w_spec_head_ptr;
  logic [COM_PTR_W-1:0]         w_com_head_ptr;
  logic [COM_PTR_W-1:0]         w_com_young_ptr;
  logic [SPEC_CNT_W-1:0]        w_spec_count;
  logic [COM_CNT_W-1:0]         w_com_count;
  sb_entry_t                    w_spec_head;
  sb_entry_t                    w_com_head;
  sb_entry_t                    w_com_young;
  sb_entry_t                    w_new_entry;
  sb_entry_t                    w_merged;
  logic                         w_accept;
  logic                         w_spec_nonempty;
  logic                         w_coalesce_ok;
  logic                         w_do_commit;
  logic                         w_merge;
  logic                         w_com_push;
  logic                         w_mem_pop;
  logic                         w_ack_valid;
  logic                         w_match;
  logic [OUT_W-1:0]             r_outst;

  assign ready_o         = w_spec_count < SPEC_CNT_W'(SPEC_DEPTH);
  assign w_accept        = valid_i && ready_o && !flush_i;
  assign w_spec_nonempty = w_spec_count != '0;
  assign w_spec_head     = w_spec_entries[w_spec_head_ptr];
  assign w_com_head      = w_com_entries[w_com_head_ptr];
  assign w_com_young_ptr = w_com_head_ptr + COM_PTR_W'(w_com_count - COM_CNT_W'(1));
  assign w_com_young     = w_com_entries[w_com_young_ptr];
  assign w_new_entry     = '{paddr: paddr_i, data: data_i, be: be_i, valid: 1'b1};

  // Requiring two entries keeps the merge target away from the head being offered to memory.
  assign w_coalesce_ok = COALESCE && w_spec_nonempty && (w_com_count >= COM_CNT_W'(2)) &&
                         ((w_com_young.paddr & WORD_MASK) == (w_spec_head.paddr & WORD_MASK));
  assign commit_ready_o = (w_com_count < COM_CNT_W'(COMMIT_DEPTH)) || w_coalesce_ok;
  assign w_do_commit    = commit_i && w_spec_nonempty && commit_ready_o;
  assign w_merge        = w_do_commit && w_coalesce_ok;
  assign w_com_push     = w_do_commit && !w_coalesce_ok;

  always_comb begin
    w_merged    = w_com_young;
    w_merged.be = w_com_young.be | w_spec_head.be;
    for (int b = 0; b < BE_W; b++) begin
      if (w_spec_head.be[b]) w_merged.data[8*b +: 8] = w_spec_head.data[8*b +: 8];
    end
  end

  assign mem_req_o   = (w_com_count != '0) && (r_outst < OUT_W'(MAX_OUTST));
  assign mem_addr_o  = w_com_head.paddr & WORD_MASK;
  assign mem_data_o  = w_com_head.data;
  assign mem_be_o    = w_com_head.be;
  assign w_mem_pop   = mem_req_o && mem_gnt_i;
  assign w_ack_valid = mem_ack_i && (r_outst != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_outst <= '0;
    else         r_outst <= r_outst + OUT_W'(w_mem_pop) - OUT_W'(w_ack_valid);
  end

  always_comb begin
    w_match = valid_i && ((paddr_i[SB_PAGE_OFF_W-1:0] & PAGE_MASK) == (page_offset_i & PAGE_MASK));
    for (int i = 0; i < SPEC_DEPTH; i++) begin
      if (w_spec_valid[i] && w_spec_entries[i].valid &&
          ((w_spec_entries[i].paddr[SB_PAGE_OFF_W-1:0] & PAGE_MASK) == (page_offset_i & PAGE_MASK)))
        w_match = 1'b1;
    end
    for (int i = 0; i < COMMIT_DEPTH; i++) begin
      if (w_com_valid[i] && w_com_entries[i].valid &&
          ((w_com_entries[i].paddr[SB_PAGE_OFF_W-1:0] & PAGE_MASK) == (page_offset_i & PAGE_MASK)))
        w_match = 1'b1;
    end
  end

  assign page_offset_matches_o = w_match;
  assign no_st_pending_o       = (w_com_count == '0) && (r_outst == '0);
  assign empty_o               = no_st_pending_o && !w_spec_nonempty;

  sb_ring #(.DEPTH(SPEC_DEPTH), .W(ENTRY_W)) u_spec_ring (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clr_i          (flush_i),
    .push_i         (w_accept),
    .push_data_i    (w_new_entry),
    .pop_i          (w_do_commit),
    .tail_wr_i      (1'b0),
    .tail_wr_data_i ({ENTRY_W{1'b0}}),
    .entries_o      (w_spec_entries),
    .valid_o        (w_spec_valid),
    .head_o         (w_spec_head_ptr),
    .count_o        (w_spec_count)
  );

  sb_ring #(.DEPTH(COMMIT_DEPTH), .W(ENTRY_W)) u_commit_ring (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clr_i          (1'b0),
    .push_i         (w_com_push),
    .push_data_i    (w_spec_head),
    .pop_i          (w_mem_pop),
    .tail_wr_i      (w_merge),
    .tail_wr_data_i (w_merged),
    .entries_o      (w_com_entries),
    .valid_o        (w_com_valid),
    .head_o         (w_com_head_ptr),
    .count_o        (w_com_count)
  );

endmodule

// File: tb/tb_store_coalesce_buffer.sv
// Directed self-checking bench for store_coalesce_buffer with hand-computed expectations.
module tb_store_coalesce_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [55:0] paddr_i = '0;
  logic [63:0] data_i = '0;
  logic [7:0]  be_i = '0;
  logic        commit_i = 1'b0;
  logic        commit_ready_o;
  logic [11:0] page_offset_i = '0;
  logic        page_offset_matches_o;
  logic        mem_req_o;
  logic        mem_gnt_i = 1'b0;
  logic [55:0] mem_addr_o;
  logic [63:0] mem_data_o;
  logic [7:0]  mem_be_o;
  logic        mem_ack_i = 1'b0;
  logic        no_st_pending_o;
  logic        empty_o;

  int nChecks = 0;
  int nFails  = 0;
  int grants  = 0;

  always #5 clk_i = ~clk_i;

  store_coalesce_buffer dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .flush_i               (flush_i),
    .valid_i               (valid_i),
    .ready_o               (ready_o),
    .paddr_i               (paddr_i),
    .data_i                (data_i),
    .be_i                  (be_i),
    .commit_i              (commit_i),
    .commit_ready_o        (commit_ready_o),
    .page_offset_i         (page_offset_i),
    .page_offset_matches_o (page_offset_matches_o),
    .mem_req_o             (mem_req_o),
    .mem_gnt_i             (mem_gnt_i),
    .mem_addr_o            (mem_addr_o),
    .mem_data_o            (mem_data_o),
    .mem_be_o              (mem_be_o),
    .mem_ack_i             (mem_ack_i),
    .no_st_pending_o       (no_st_pending_o),
    .empty_o               (empty_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [55:0] a, input logic [63:0] d,
                               input logic [7:0] be, input logic c, input logic f,
                               input logic g, input logic ack);
    valid_i   = v;
    paddr_i   = a;
    data_i    = d;
    be_i      = be;
    commit_i  = c;
    flush_i   = f;
    mem_gnt_i = g;
    mem_ack_i = ack;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pushStore(input logic [55:0] a, input logic [63:0] d, input logic [7:0] be);
    applyStimulus(1'b1, a, d, be, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset state
    idle();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    #1;
    checkOutput("rst_ready", 64'(ready_o), 64'd1);
    checkOutput("rst_commit_ready", 64'(commit_ready_o), 64'd1);
    checkOutput("rst_mem_req", 64'(mem_req_o), 64'd0);
    checkOutput("rst_match", 64'(page_offset_matches_o), 64'd0);
    checkOutput("rst_no_st_pending", 64'(no_st_pending_o), 64'd1);
    checkOutput("rst_empty", 64'(empty_o), 64'd1);

    // Fill the speculative queue; the fifth offer must bounce
    for (int i = 0; i < 4; i++) pushStore(56'h100 + 56'(8 * i), 64'h1000_0000_0000_0000 + 64'(i), 8'hFF);
    idle();
    #1;
    checkOutput("full_ready", 64'(ready_o), 64'd0);
    checkOutput("full_empty", 64'(empty_o), 64'd0);
    applyStimulus(1'b1, 56'h120, 64'hDEAD, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("fifth_ready", 64'(ready_o), 64'd0);
    tick();
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("full_commit_ready_same_cycle", 64'(ready_o), 64'd0);
    checkOutput("full_commit_ready_o", 64'(commit_ready_o), 64'd1);
    for (int i = 0; i < 5; i++) tick();
    idle();
    #1;
    checkOutput("after_commit_ready", 64'(ready_o), 64'd1);
    checkOutput("after_commit_pending", 64'(no_st_pending_o), 64'd0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("drain4_req", 64'(mem_req_o), 64'd1);
      checkOutput("drain4_addr", 64'(mem_addr_o), 64'h100 + 64'(8 * i));
      checkOutput("drain4_data", mem_data_o, 64'h1000_0000_0000_0000 + 64'(i));
      tick();
    end
    #1;
    checkOutput("drain4_done_req", 64'(mem_req_o), 64'd0);
    tick();
    idle();
    #1;
    checkOutput("drain4_no_st_pending", 64'(no_st_pending_o), 64'd1);
    checkOutput("drain4_empty", 64'(empty_o), 64'd1);

    // Write-combining of two stores to the same word
    pushStore(56'h1000, 64'h1111_1111_1111_1111, 8'h0F);
    pushStore(56'h2000, 64'hBBBB_BBBB_BBBB_BBBB, 8'h0F);
    pushStore(56'h2000, 64'hCCCC_CCCC_CCCC_CCCC, 8'hF0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    idle();
    #1;
    checkOutput("merge_head_addr", 64'(mem_addr_o), 64'h1000);
    checkOutput("merge_head_be", 64'(mem_be_o), 64'h0F);
    checkOutput("merge_head_data", mem_data_o, 64'h1111_1111_1111_1111);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    #1;
    checkOutput("merge_addr", 64'(mem_addr_o), 64'h2000);
    checkOutput("merge_be", 64'(mem_be_o), 64'hFF);
    checkOutput("merge_data", mem_data_o, 64'hCCCC_CCCC_BBBB_BBBB);
    tick();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    #1;
    checkOutput("merge_only_two_req", 64'(mem_req_o), 64'd0);
    checkOutput("merge_one_outst", 64'(no_st_pending_o), 64'd0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    #1;
    checkOutput("merge_empty", 64'(empty_o), 64'd1);

    // Flush together with a commit; the flush-cycle store is dropped
    pushStore(56'h300, 64'h3000, 8'hFF);
    pushStore(56'h308, 64'h3008, 8'hFF);
    pushStore(56'h310, 64'h3010, 8'hFF);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 56'h318, 64'h3018, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    checkOutput("flush_ready", 64'(ready_o), 64'd1);
    checkOutput("flush_empty", 64'(empty_o), 64'd0);
    checkOutput("flush_pending", 64'(no_st_pending_o), 64'd0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("flush_drain0", 64'(mem_addr_o), 64'h300);
    tick();
    #1;
    checkOutput("flush_drain1", 64'(mem_addr_o), 64'h308);
    tick();
    #1;
    checkOutput("flush_drain_done_req", 64'(mem_req_o), 64'd0);
    tick();
    idle();
    #1;
    checkOutput("flush_final_empty", 64'(empty_o), 64'd1);

    // Outstanding limit with grants every cycle and no acks
    pushStore(56'h400, 64'h4000, 8'hFF);
    pushStore(56'h408, 64'h4008, 8'hFF);
    pushStore(56'h410, 64'h4010, 8'hFF);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    grants = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (mem_req_o) grants++;
      tick();
    end
    checkOutput("outst_grants", 64'(grants), 64'd2);
    checkOutput("outst_req_blocked", 64'(mem_req_o), 64'd0);
    checkOutput("outst_pending", 64'(no_st_pending_o), 64'd0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("outst_req_after_ack", 64'(mem_req_o), 64'd1);
    checkOutput("outst_third_addr", 64'(mem_addr_o), 64'h410);
    tick();
    #1;
    checkOutput("outst_req_blocked2", 64'(mem_req_o), 64'd0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    #1;
    checkOutput("outst_pending_2nd_ack", 64'(no_st_pending_o), 64'd0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    #1;
    checkOutput("outst_pending_3rd_ack", 64'(no_st_pending_o), 64'd1);

    // Reset in the middle of traffic, then a stray ack
    pushStore(56'h500, 64'h5000, 8'hFF);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    pushStore(56'h508, 64'h5008, 8'hFF);
    idle();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    #1;
    checkOutput("midrst_empty", 64'(empty_o), 64'd1);
    checkOutput("midrst_req", 64'(mem_req_o), 64'd0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    #1;
    checkOutput("late_ack_ignored", 64'(no_st_pending_o), 64'd1);
    pushStore(56'h600, 64'h6000, 8'hFF);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    checkOutput("post_rst_req", 64'(mem_req_o), 64'd1);
    checkOutput("post_rst_addr", 64'(mem_addr_o), 64'h600);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    #1;
    checkOutput("post_rst_empty", 64'(empty_o), 64'd1);

    // Page-offset word matching against queued entries and the incoming store
    pushStore(56'h8000_1238, 64'h0, 8'hFF);
    idle();
    page_offset_i = 12'h23C;
    #1;
    checkOutput("match_same_word", 64'(page_offset_matches_o), 64'd1);
    page_offset_i = 12'h240;
    #1;
    checkOutput("match_next_word", 64'(page_offset_matches_o), 64'd0);
    applyStimulus(1'b1, 56'h1240, 64'h0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("match_incoming", 64'(page_offset_matches_o), 64'd1);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    page_offset_i = 12'h23C;
    #1;
    checkOutput("match_commit_queue", 64'(page_offset_matches_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
